uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART transmitter between two byte sources: the CPU's memory-mapped UART-TX register write path and the UART-RX echo path. Each source gets a one-entry holding buffer with a valid/ready handshake. Buffered bytes are granted to the transmitter round-robin; the block drives a one-cycle start strobe and tracks the transmitter's busy line through the whole frame. It sits between the peripheral decode logic of the pipelined CPU and the UART sender, and exports a busy flag for the CPU-visible UART status register.

## Interface
- DW, 8, data width of a UART byte
- TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before abandoning the transfer (≥2)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_valid  in  1  CPU has a byte to send
- cpu_data  in  DW  CPU byte
- cpu_ready  out  1  CPU holding buffer empty; transfer occurs at an edge with cpu_valid&cpu_ready
- echo_valid  in  1  RX echo path has a byte
- echo_data  in  DW  echo byte
- echo_ready  out  1  echo holding buffer empty
- tx_data  out  DW  byte presented to the UART sender; stable from tx_start until next grant
- tx_start  out  1  one-cycle start strobe to the sender
- tx_busy  in  1  sender shifting a frame
- grant_id  out  1  owner of the current/last transfer (0 = CPU, 1 = echo)
- busy  out  1  arbiter not in IDLE
- tx_err  out  1  one-cycle pulse on start timeout

## Operation
- Holding buffers: hold_valid[i] is set at an edge with valid_i & ready_i, and hold_data[i] loads on that edge. ready_i = ~hold_valid[i] (combinational from the register). hold_valid[i] clears at the grant edge.
- Round-robin: the last_grant register resets to 1, so the CPU wins the first tie. When both buffers are valid, grant ~last_grant. When only one is valid, grant it. last_grant updates at every grant.
- FSM states: IDLE, WAIT_HI, WAIT_LO.
  - IDLE: if any hold_valid, then at the next edge go to WAIT_HI. On that same edge: tx_data <= hold_data[sel], grant_id <= sel, tx_start <= 1, clear hold_valid[sel], counter <= 0.
  - WAIT_HI: tx_start returns to 0 after one cycle. If tx_busy=1, go to WAIT_LO. Otherwise increment the counter. If the counter = TIMEOUT-1 with tx_busy=0, go to IDLE and pulse tx_err for one cycle.
  - WAIT_LO: when tx_busy=0, go to IDLE.
- busy = (state != IDLE).
- A byte granted then timed out is dropped, not retried.
- Simultaneous accept and grant on the same buffer cannot occur because ready=0 while the buffer is full. The freed buffer accepts again from the cycle after the grant.
- Reset (asynchronous, any state): state=IDLE, both hold_valid=0 (pending bytes discarded), last_grant=1, tx_start=0, tx_data=0, grant_id=0, tx_err=0, busy=0, cpu_ready=echo_ready=1.

## Timing
- Accept edge E0 → grant edge E1 (if IDLE) → tx_start high during cycle E1..E2. Latency from accept to strobe is 1 edge; the strobe is visible in the 2nd cycle after valid is first presented.
- tx_start is exactly one cycle wide and is never reasserted before the FSM has returned to IDLE.
- Back-to-back: tx_busy falls at cycle t → IDLE at edge t+1 → next grant at edge t+2 if a buffer is valid.
- Throughput limit is one byte per frame + 2 cycles. The holding buffers give each source one byte of slack while a frame is in flight.
- tx_err is asserted in the cycle after the timeout edge, for one cycle. busy=0 in the same cycle.

## Test plan
- Reset: hold reset high with inputs random, then release. Required: tx_start=0, tx_data=0x00, busy=0, tx_err=0, cpu_ready=echo_ready=1, grant_id=0.
- Single CPU byte: cpu_valid for 1 cycle with 0x41. Sender model raises tx_busy 1 cycle after tx_start and holds it 10 cycles. Required: tx_start pulse 1 cycle wide, tx_data=0x41, grant_id=0; busy falls 1 cycle after tx_busy falls; cpu_ready back to 1 the cycle after the grant.
- Contention: both sources kept continuously valid, CPU sending 0x55 repeatedly and echo sending 0xAA repeatedly. Required: the transmitter sees 0x55, 0xAA, 0x55, 0xAA, with grant_id alternating 0,1,0,1 and never two consecutive grants to one source.
- Back-pressure: CPU sends 0x01, then 0x02 while the 0x01 frame is in flight, then 0x03. Required: 0x02 accepted (cpu_ready was 1 after the grant); 0x03 stalled with cpu_ready=0 until 0x02 is granted; output order 0x01, 0x02, 0x03.
- Start timeout: tx_busy tied to 0 with TIMEOUT=4, send 0x7E. Required: tx_err pulses once 4 cycles after the tx_start cycle and the FSM returns to IDLE. A following byte 0x11 is then transmitted normally once tx_busy modelling is restored.
- Reset mid-frame: assert reset in WAIT_LO with the echo buffer holding 0x33. Required: outputs take reset values immediately without waiting for a clock edge; 0x33 is never transmitted after release; a new CPU byte afterwards is served normally.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake and transmitter signals between the UART TX arbiter and its neighbours.
// slave = arbiter side, master = sources/sender side.
interface uart_tx_arbiter_if #(
    parameter int unsigned DW = 8
);
    logic          cpu_valid;
    logic [DW-1:0] cpu_data;
    logic          cpu_ready;
    logic          echo_valid;
    logic [DW-1:0] echo_data;
    logic          echo_ready;
    logic [DW-1:0] tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          grant_id;
    logic          busy;
    logic          tx_err;

    modport slave (
        input  cpu_valid, cpu_data, echo_valid, echo_data, tx_busy,
        output cpu_ready, echo_ready, tx_data, tx_start, grant_id, busy, tx_err
    );

    modport master (
        output cpu_valid, cpu_data, echo_valid, echo_data, tx_busy,
        input  cpu_ready, echo_ready, tx_data, tx_start, grant_id, busy, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the CPU write path and RX echo.
// Each source owns a one-entry holding buffer; the FSM strobes tx_start and follows tx_busy.
module uart_tx_arbiter #(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 4
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StWaitHi, StWaitLo} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             hold_valid_q, hold_valid_d;
    logic [1:0][DW-1:0]     hold_data_q;
    logic                   last_grant_q, last_grant_d;
    logic                   grant_q, grant_d;
    logic [DW-1:0]          tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   tx_err_q, tx_err_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [1:0]             accept;
    logic                   sel;

    // Index 0 is the CPU source, index 1 the echo source.
    assign accept = {bus.echo_valid & ~hold_valid_q[1], bus.cpu_valid & ~hold_valid_q[0]};
    assign sel    = (&hold_valid_q) ? ~last_grant_q : hold_valid_q[1];

    assign bus.cpu_ready  = ~hold_valid_q[0];
    assign bus.echo_ready = ~hold_valid_q[1];
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.grant_id   = grant_q;
    assign bus.tx_err     = tx_err_q;
    assign bus.busy       = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q | accept;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        tx_err_d     = 1'b0;
        cnt_d        = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (|hold_valid_q) begin
                    state_d           = StWaitHi;
                    tx_data_d         = hold_data_q[sel];
                    grant_d           = sel;
                    last_grant_d      = sel;
                    tx_start_d        = 1'b1;
                    hold_valid_d[sel] = 1'b0;
                    cnt_d             = '0;
                end
            end
            StWaitHi: begin
                if (bus.tx_busy) begin
                    state_d = StWaitLo;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    // Sender never acknowledged: drop the byte rather than retry.
                    state_d  = StIdle;
                    tx_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitLo: begin
                if (!bus.tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            hold_valid_q <= '0;
            hold_data_q  <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_err_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            tx_err_q     <= tx_err_d;
            cnt_q        <= cnt_d;
            if (accept[0]) hold_data_q[0] <= bus.cpu_data;
            if (accept[1]) hold_data_q[1] <= bus.echo_data;
        end
    end
endmodule
